fc_tx_scheduler: RTL

Transmit-side flow-control scheduler for the PCIe TLP path. It arbitrates round-robin among three TLP requesters: Posted, Non-Posted and Completion. It grants a requester only when the per-class header and data credits pass the modular credit-gating check. It owns the six CREDITS_CONSUMED counters and the six CREDIT_LIMIT registers, which are loaded at initialisation and refreshed by received UpdateFC information. It sits between the TLP source queues and the transaction-layer transmit mux.

---
 rtl/fc_tx_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fc_tx_scheduler.sv
// Transmit-side flow-control scheduler for the TLP path.
// Round-robin arbitration among Posted, Non-Posted and Completion requesters,
// gated by modular header/data credit checks against CREDIT_LIMIT registers.
module fc_tx_scheduler #(
  parameter int HDR_WIDTH = 8,
  parameter int DAT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           req,
  input  logic [DAT_WIDTH-1:0] p_dat_need,
  input  logic [DAT_WIDTH-1:0] np_dat_need,
  input  logic [DAT_WIDTH-1:0] cpl_dat_need,
  input  logic                 init_valid,
  input  logic [HDR_WIDTH-1:0] init_ph,
  input  logic [HDR_WIDTH-1:0] init_nph,
  input  logic [HDR_WIDTH-1:0] init_ch,
  input  logic [DAT_WIDTH-1:0] init_pd,
  input  logic [DAT_WIDTH-1:0] init_npd,
  input  logic [DAT_WIDTH-1:0] init_cd,
  input  logic                 upd_valid,
  input  logic [1:0]           upd_type,
  input  logic [HDR_WIDTH-1:0] upd_hdr,
  input  logic [DAT_WIDTH-1:0] upd_dat,
  input  logic                 tx_done,
  output logic [2:0]           grant,
  output logic                 busy,
  output logic [2:0]           blocked
);

  typedef enum logic [1:0] {IDLE, CHECK, GRANT} state_e;

  // Half of each modulus: a remaining-credit difference above this means "negative".
  localparam logic [HDR_WIDTH-1:0] HDR_HALF = HDR_WIDTH'(1) << (HDR_WIDTH - 1);
  localparam logic [DAT_WIDTH-1:0] DAT_HALF = DAT_WIDTH'(1) << (DAT_WIDTH - 1);

  state_e               state_q, state_d;
  logic [1:0]           rr_q, rr_d;         // class index: 0 P, 1 NP, 2 Cpl
  logic [1:0]           gsel_q, gsel_d;     // class currently granted
  logic [2:0]           req_q, req_d;       // request mask captured in IDLE
  logic [2:0]           blocked_q, blocked_d;
  logic [DAT_WIDTH-1:0] need_q [3];
  logic [DAT_WIDTH-1:0] need_d [3];
  logic [HDR_WIDTH-1:0] hc_q [3];           // header CREDITS_CONSUMED
  logic [HDR_WIDTH-1:0] hc_d [3];
  logic [DAT_WIDTH-1:0] dc_q [3];           // data CREDITS_CONSUMED
  logic [DAT_WIDTH-1:0] dc_d [3];
  logic [HDR_WIDTH-1:0] hl_q [3];           // header CREDIT_LIMIT
  logic [HDR_WIDTH-1:0] hl_d [3];
  logic [DAT_WIDTH-1:0] dl_q [3];           // data CREDIT_LIMIT
  logic [DAT_WIDTH-1:0] dl_d [3];

  logic [DAT_WIDTH-1:0] need_in [3];
  logic [HDR_WIDTH-1:0] init_h  [3];
  logic [DAT_WIDTH-1:0] init_d  [3];
  logic [HDR_WIDTH-1:0] hdr_room [3];
  logic [DAT_WIDTH-1:0] dat_room [3];
  logic [2:0]           elig;
  logic                 found;
  logic [1:0]           pick;
  logic [1:0]           cand;

  assign need_in[0] = p_dat_need;
  assign need_in[1] = np_dat_need;
  assign need_in[2] = cpl_dat_need;
  assign init_h[0]  = init_ph;
  assign init_h[1]  = init_nph;
  assign init_h[2]  = init_ch;
  assign init_d[0]  = init_pd;
  assign init_d[1]  = init_npd;
  assign init_d[2]  = init_cd;

  function automatic logic [1:0] next_cls(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Modular credit-gating check on the captured request and registered limits.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      hdr_room[c] = hl_q[c] - (hc_q[c] + HDR_WIDTH'(1));
      dat_room[c] = dl_q[c] - (dc_q[c] + need_q[c]);
      elig[c]     = req_q[c] && (hdr_room[c] <= HDR_HALF) && (dat_room[c] <= DAT_HALF);
    end
  end

  // Round-robin pick: first eligible class at or after the pointer.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = rr_q;
    for (int k = 0; k < 3; k++) begin
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
      cand = next_cls(cand);
    end
  end

  // Next-state logic: FSM, credit accounting, limit loading.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned (no latches).
    state_d   = state_q;
    rr_d      = rr_q;
    gsel_d    = gsel_q;
    req_d     = req_q;
    blocked_d = blocked_q;
    need_d    = need_q;
    hc_d      = hc_q;
    dc_d      = dc_q;
    hl_d      = hl_q;
    dl_d      = dl_q;

    unique case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          req_d   = req;
          need_d  = need_in;
          state_d = CHECK;
        end
      end
      CHECK: begin
        blocked_d = req_q & ~elig;
        if (found) begin
          gsel_d     = pick;
          hc_d[pick] = hc_q[pick] + HDR_WIDTH'(1);
          dc_d[pick] = dc_q[pick] + need_q[pick];
          state_d    = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (tx_done) begin
          rr_d    = next_cls(gsel_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // UpdateFC only refreshes limits; consumed counters are untouched.
    if (upd_valid && (upd_type != 2'b11)) begin
      hl_d[upd_type] = upd_hdr;
      dl_d[upd_type] = upd_dat;
    end

    // Initialisation overrides UpdateFC, tx_done and any grant decision.
    if (init_valid) begin
      hl_d      = init_h;
      dl_d      = init_d;
      hc_d      = '{default: '0};
      dc_d      = '{default: '0};
      rr_d      = rr_q;
      blocked_d = blocked_q;
      state_d   = IDLE;
    end
  end

  // State and credit registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 2'd0;
      gsel_q    <= 2'd0;
      req_q     <= 3'b000;
      blocked_q <= 3'b000;
      // NOTE: the counter/limit arrays are real credit state, so they are reset, not left as X.
      for (int c = 0; c < 3; c++) begin
        need_q[c] <= '0;
        hc_q[c]   <= '0;
        dc_q[c]   <= '0;
        hl_q[c]   <= '0;
        dl_q[c]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      rr_q      <= rr_d;
      gsel_q    <= gsel_d;
      req_q     <= req_d;
      blocked_q <= blocked_d;
      need_q    <= need_d;
      hc_q      <= hc_d;
      dc_q      <= dc_d;
      hl_q      <= hl_d;
      dl_q      <= dl_d;
    end
  end

  assign grant   = (state_q == GRANT) ? (3'b001 << gsel_q) : 3'b000;
  assign busy    = (state_q != IDLE);
  assign blocked = blocked_q;

endmodule
